// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   W        operand/result width (only 4 is supported)
//   OP_*     opcode encodings; 100-111 are illegal
//   state_t  response-slot state (EMPTY / FULL)
package alu_pkg;

   localparam int unsigned W = 4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin choice.
//   valid[1:0]  requester n has work pending
//   last_grant  index of the most recently accepted requester
//   slot_free   downstream can take a transfer this cycle
//   grant[1:0]  one-hot (or zero) winner
module rr_pick (
   input  logic [1:0] valid,
   input  logic       last_grant,
   input  logic       slot_free,
   output logic [1:0] grant
);

   always_comb begin
      grant = '0;
      if (slot_free) begin
         // On a tie, the requester that did not win last time goes first.
         if (valid[0] && (!valid[1] || last_grant)) begin
            grant[0] = 1'b1;
         end else if (valid[1]) begin
            grant[1] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through round-robin arbitration and a
// one-entry registered response slot.
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         requester handshake (N = 0, 1)
//   reqN_a/b/c/op            operands, carry/borrow-in, opcode
//   rsp_valid/ready          response handshake
//   rsp_id/result/carry/err  held response
// Optional: define ALU_ARB_ZERO_FLAG_EN to add rsp_zero (result == 0).
module alu_arbiter #(
   parameter int unsigned W = alu_pkg::W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req0_c,
   input  logic [2:0]   req0_op,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic         req1_c,
   input  logic [2:0]   req1_op,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_result,
   output logic         rsp_carry,
   output logic         rsp_err
`ifdef ALU_ARB_ZERO_FLAG_EN
   ,output logic        rsp_zero
`endif
);

   import alu_pkg::*;

   state_t       state, state_nxt;
   logic         last_grant;
   logic         slot_free;
   logic [1:0]   grant;
   logic         accept;

   logic [W-1:0] op_a, op_b;
   logic         op_c;
   logic [2:0]   op_code;
   logic [W:0]   alu_wide;
   logic         alu_err;

   // A full slot being drained this cycle can be refilled in the same cycle.
   assign slot_free = (state == EMPTY) || rsp_ready;

   rr_pick u_pick (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .slot_free  (slot_free && !rst),
      .grant      (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign accept     = |grant;
   assign rsp_valid  = (state == FULL);

   always_comb begin
      op_a    = req0_a;
      op_b    = req0_b;
      op_c    = req0_c;
      op_code = req0_op;
      if (grant[1]) begin
         op_a    = req1_a;
         op_b    = req1_b;
         op_c    = req1_c;
         op_code = req1_op;
      end
   end

   // Bit W carries ADD carry-out or SUB borrow (the difference wraps negative).
   always_comb begin
      alu_wide = '0;
      alu_err  = 1'b0;
      case (op_code)
         OP_ADD:  alu_wide = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_c};
         OP_SUB:  alu_wide = {1'b0, op_a} - {1'b0, op_b} - {{W{1'b0}}, op_c};
         OP_AND:  alu_wide = {1'b0, op_a & op_b};
         OP_OR:   alu_wide = {1'b0, op_a | op_b};
         default: alu_err  = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (accept) state_nxt = FULL;
         FULL:    if (rsp_ready && !accept) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_err    <= 1'b0;
`ifdef ALU_ARB_ZERO_FLAG_EN
         rsp_zero   <= 1'b0;
`endif
      end else if (accept) begin
         last_grant <= grant[1];
         rsp_id     <= grant[1];
         rsp_result <= alu_wide[W-1:0];
         rsp_carry  <= alu_wide[W];
         rsp_err    <= alu_err;
`ifdef ALU_ARB_ZERO_FLAG_EN
         rsp_zero   <= (alu_wide[W-1:0] == '0);
`endif
      end
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: W, 4, operand/result width; only 4 is supported.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid / req1_valid  input  1 each  requester n has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  requester n's operation is accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  W each  operands.
REQ-007 req0_c / req1_c  input  1 each  carry-in / borrow-in.
REQ-008 req0_op / req1_op  input  3 each  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100-111 illegal.
REQ-009 rsp_valid  output  1  response register holds a result.
REQ-010 rsp_ready  input  1  consumer takes the response this cycle.
REQ-011 rsp_id  output  1  requester index of the held response.
REQ-012 rsp_result  output  W  registered result.
REQ-013 rsp_carry  output  1  carry for ADD, borrow for SUB, 0 otherwise.
REQ-014 rsp_err  output  1  held response came from an illegal opcode.

Function
REQ-015 The block SHALL share one 4-bit ALU between two requesters, using round-robin arbitration and a one-entry registered response.
REQ-016 Slot free = !rsp_valid | rsp_ready (same-cycle drain and refill).
REQ-017 reqN_ready SHALL be 1 only when the slot is free and requester N wins arbitration; at most one ready per cycle.
REQ-018 Arbitration: if only one requester is valid, it wins; if both are valid, the requester other than last_grant wins.
REQ-019 last_grant SHALL update only on an accepted transfer (valid&ready).
REQ-020 Latency: a transfer accepted in cycle N SHALL appear with rsp_valid=1 in cycle N+1.
REQ-021 ADD: result = (A+B+c) mod 16, carry = bit 4 of the sum.
REQ-022 SUB: result = (A-B-c) mod 16, carry = 1 when A < B+c.
REQ-023 AND/OR: bitwise result, carry = 0.
REQ-024 Illegal opcode: the transfer SHALL still be accepted, with result = 0, carry = 0, err = 1; the response SHALL never be high-Z.
REQ-025 FSM states:
- EMPTY: rsp_valid=0.
- FULL: rsp_valid=1.
REQ-026 FSM transitions:
- EMPTY to FULL on accept.
- FULL to EMPTY on rsp_ready with no accept.
- FULL stays FULL on rsp_ready with accept, loading new data.
- FULL with rsp_ready=0 SHALL hold all rsp_* outputs stable.
REQ-027 Requester inputs SHALL be sampled only in the accept cycle; changes after acceptance have no effect.

Reset
REQ-028 While rst=1 at a clock edge: state = EMPTY, rsp_valid = 0, rsp_id/rsp_result/rsp_carry/rsp_err = 0, last_grant = 1 (so req0 wins the first tie).
REQ-029 While rst=1, both reqN_ready SHALL be 0.
REQ-030 Reset asserted while in FULL SHALL discard the held response without requiring rsp_ready.

Configuration
REQ-031 Macro ALU_ARB_ZERO_FLAG_EN: when defined, an extra output rsp_zero (1 bit, registered with the response, 1 when rsp_result == 0, reset 0) SHALL exist.
REQ-032 When ALU_ARB_ZERO_FLAG_EN is undefined, the rsp_zero port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package alu_pkg SHALL hold: W, opcode constants OP_ADD/OP_SUB/OP_AND/OP_OR, and the FSM state enum (EMPTY, FULL).
REQ-034 One sub-module, rr_pick, SHALL implement the two-way round-robin choice: inputs valid[1:0], last_grant, slot_free; outputs grant[1:0].
REQ-035 ALU arithmetic SHALL be combinational inside alu_arbiter, feeding the response register.

Verification
REQ-036 Reset: rst=1 for 2 cycles -> rsp_valid=0, rsp_result=0, both ready=0; first tie after reset grants req0.
REQ-037 req0 only, ADD A=7 B=9 c=0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=0, rsp_carry=1, rsp_err=0.
REQ-038 Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; one result per cycle; no idle cycle.
REQ-039 req1 SUB A=3 B=5 c=1, rsp_ready=0 for 3 cycles -> rsp_result=13, rsp_carry=1 held stable; both ready=0 until rsp_ready=1.
REQ-040 req0 op=101 A=15 B=15 -> rsp_err=1, rsp_result=0, rsp_carry=0; the next legal op OR A=5 B=10 -> result 15, err=0.
REQ-041 Reset asserted while FULL with rsp_ready=0 -> next cycle rsp_valid=0; with ALU_ARB_ZERO_FLAG_EN defined, AND A=12 B=3 -> rsp_zero=1.
